hazard_ctrl: RTL and testbench

// - Pipeline sequencer for the execute stage: decides each cycle whether decode may issue into execute, stalls, or is squashed.
// - Tracks in-flight destination registers across the EX/MEM/WB slots and stalls decode on RAW hazards (no forwarding exists).
// - Converts an execute-stage branch/jump flush into a front-end squash plus a registered fetch redirect, followed by a bubble window.
// - Sits beside fetch/decode/execute/memory. Drives their stall/flush inputs and the fetch PC redirect.

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode/execute/memory side-band bundle for the hazard sequencer
interface hazard_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              dec_valid;
  logic [4:0]        dec_rs1;
  logic [4:0]        dec_rs2;
  logic              dec_rs1_used;
  logic              dec_rs2_used;
  logic [4:0]        dec_rd;
  logic              dec_rd_wr;
  logic              ex_flush;
  logic [ADDR_W-1:0] ex_flush_addr;
  logic              mem_stall;
  logic              stall_fetch;
  logic              stall_decode;
  logic              stall_execute;
  logic              stall_mem;
  logic              flush_fd;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic [CNT_W-1:0]  perf_stall_cnt;
  logic [CNT_W-1:0]  perf_flush_cnt;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd, dec_rd_wr,
    output ex_flush, ex_flush_addr, mem_stall,
    input  stall_fetch, stall_decode, stall_execute, stall_mem, flush_fd,
    input  redirect_valid, redirect_addr, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd, dec_rd_wr,
    input  ex_flush, ex_flush_addr, mem_stall,
    output stall_fetch, stall_decode, stall_execute, stall_mem, flush_fd,
    output redirect_valid, redirect_addr, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - execute-stage pipeline sequencer: RAW stalls, flush/redirect, bubble window
module hazard_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  localparam logic [3:0] FCNT_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [0:0]        state;
  logic [3:0]        fcnt;

  // In-flight destination tracker; a slot is only valid for a real write to rd!=0
  logic              ex_v, mem_v, wb_v;
  logic [4:0]        ex_rd, mem_rd, wb_rd;

  logic              rs1_hit, rs2_hit, hazard;
  logic              flush_acc, stall_dec, issue;

  logic              redirect_valid_q;
  logic [ADDR_W-1:0] redirect_addr_q;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  // Hazard detection and per-cycle issue/stall/flush decisions
  always_comb begin
    rs1_hit   = (ex_v  && ex_rd  == bus.dec_rs1) ||
                (mem_v && mem_rd == bus.dec_rs1) ||
                (wb_v  && wb_rd  == bus.dec_rs1);
    rs2_hit   = (ex_v  && ex_rd  == bus.dec_rs2) ||
                (mem_v && mem_rd == bus.dec_rs2) ||
                (wb_v  && wb_rd  == bus.dec_rs2);
    hazard    = bus.dec_valid &&
                ((bus.dec_rs1_used && bus.dec_rs1 != 5'd0 && rs1_hit) ||
                 (bus.dec_rs2_used && bus.dec_rs2 != 5'd0 && rs2_hit));
    // A flush arriving during a back-end freeze is not taken; execute re-presents it
    flush_acc = bus.ex_flush && !bus.mem_stall;
    stall_dec = bus.mem_stall || (!bus.ex_flush && hazard && state == ST_RUN);
    issue     = bus.dec_valid && state == ST_RUN && !hazard && !bus.ex_flush && !bus.mem_stall;
  end

  assign bus.stall_execute  = bus.mem_stall;
  assign bus.stall_mem      = bus.mem_stall;
  assign bus.stall_decode   = stall_dec;
  assign bus.stall_fetch    = stall_dec;
  assign bus.flush_fd       = flush_acc;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_addr  = redirect_addr_q;
  assign bus.perf_stall_cnt = stall_cnt;
  assign bus.perf_flush_cnt = flush_cnt;

  // Tracker advances one slot per unfrozen cycle; EX receives the issued writer or a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v   <= 1'b0;
      mem_v  <= 1'b0;
      wb_v   <= 1'b0;
      ex_rd  <= 5'd0;
      mem_rd <= 5'd0;
      wb_rd  <= 5'd0;
    end else if (!bus.mem_stall) begin
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      ex_v   <= issue && bus.dec_rd_wr && bus.dec_rd != 5'd0;
      ex_rd  <= issue ? bus.dec_rd : 5'd0;
    end
  end

  // RUN/FLUSH sequencing; a flush in either state (re)loads the bubble window
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      fcnt  <= 4'd0;
    end else if (!bus.mem_stall) begin
      if (bus.ex_flush) begin
        state <= ST_FLUSH;
        fcnt  <= FCNT_LOAD;
      end else if (state == ST_FLUSH) begin
        if (fcnt == 4'd0) begin
          state <= ST_RUN;
        end else begin
          fcnt <= fcnt - 4'd1;
        end
      end
    end
  end

  // Registered fetch redirect: one-cycle pulse, address held until the next flush
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
    end else begin
      redirect_valid_q <= flush_acc;
      if (flush_acc) begin
        redirect_addr_q <= bus.ex_flush_addr;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_dec && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_acc && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized self-checking bench for hazard_ctrl against a queue-level model
module tb_hazard_ctrl;
  localparam int ADDR_W       = 16;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 5;
  localparam longint CNT_MAX  = (64'd1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Model: destination regs of the three in-flight instructions (0 = nothing tracked),
  // remaining bubble cycles after a redirect, and the registered outputs.
  int     pipe[3];
  int     bubbles;
  bit     m_rv;
  longint m_ra, m_sc, m_fc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_flight(input int r);
    return r != 0 && (pipe[0] == r || pipe[1] == r || pipe[2] == r);
  endfunction

  task automatic model_reset();
    pipe[0] = 0; pipe[1] = 0; pipe[2] = 0;
    bubbles = 0;
    m_rv = 0; m_ra = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic step(input bit r, input bit dv, input bit [4:0] s1, input bit [4:0] s2,
                      input bit u1, input bit u2, input bit [4:0] d, input bit w,
                      input bit fl, input bit [ADDR_W-1:0] fa, input bit ms);
    bit haz, sd, acc, iss;
    @(posedge clk);
    #1;
    reset = r;
    bus.dec_valid = dv; bus.dec_rs1 = s1; bus.dec_rs2 = s2;
    bus.dec_rs1_used = u1; bus.dec_rs2_used = u2;
    bus.dec_rd = d; bus.dec_rd_wr = w;
    bus.ex_flush = fl; bus.ex_flush_addr = fa; bus.mem_stall = ms;
    #1;
    haz = dv && ((u1 && in_flight(int'(s1))) || (u2 && in_flight(int'(s2))));
    sd  = ms || (!fl && haz && bubbles == 0);
    acc = fl && !ms;
    check_eq("stall_decode",   64'(bus.stall_decode),   64'(sd));
    check_eq("stall_fetch",    64'(bus.stall_fetch),    64'(sd));
    check_eq("stall_execute",  64'(bus.stall_execute),  64'(ms));
    check_eq("stall_mem",      64'(bus.stall_mem),      64'(ms));
    check_eq("flush_fd",       64'(bus.flush_fd),       64'(acc));
    check_eq("redirect_valid", 64'(bus.redirect_valid), 64'(m_rv));
    check_eq("redirect_addr",  64'(bus.redirect_addr),  64'(m_ra));
    check_eq("perf_stall_cnt", 64'(bus.perf_stall_cnt), 64'(m_sc));
    check_eq("perf_flush_cnt", 64'(bus.perf_flush_cnt), 64'(m_fc));
    // advance the model to the state after the coming edge
    if (r) begin
      model_reset();
    end else begin
      m_rv = acc;
      if (acc) m_ra = longint'(fa);
      if (sd && m_sc < CNT_MAX) m_sc++;
      if (acc && m_fc < CNT_MAX) m_fc++;
      if (!ms) begin
        iss = dv && bubbles == 0 && !haz && !fl;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (iss && w) ? int'(d) : 0;
        if (fl) bubbles = FLUSH_CYCLES;
        else if (bubbles > 0) bubbles--;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.dec_valid = 0; bus.dec_rs1 = 0; bus.dec_rs2 = 0;
    bus.dec_rs1_used = 0; bus.dec_rs2_used = 0; bus.dec_rd = 0; bus.dec_rd_wr = 0;
    bus.ex_flush = 0; bus.ex_flush_addr = 0; bus.mem_stall = 0;
    repeat (3) @(posedge clk);
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // back-to-back RAW on x5: three stalled cycles, issues on the fourth
    step(0, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
    idle(3);
    // x0 writer then x0 reader; then rs2 matching but unused
    step(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 7, 1, 0, 0, 0);
    step(0, 1, 0, 7, 0, 0, 8, 0, 0, 0, 0);
    idle(3);
    // taken branch to 0x100, then two bubble cycles with decode still offering
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0100, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    // flush held during a three-cycle freeze, accepted on the fourth
    for (int i = 0; i < 3; i++) step(0, 1, 9, 0, 1, 0, 3, 1, 1, 16'h0200, 1);
    step(0, 1, 9, 0, 1, 0, 3, 1, 1, 16'h0200, 0);
    idle(3);
    // hazard and flush in the same cycle
    step(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    step(0, 1, 4, 0, 1, 0, 2, 1, 1, 16'h0300, 0);
    idle(1);
    // reset while in FLUSH with tracked writers
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 1, 1, 16'h0400, 0);
    step(1, 1, 3, 1, 1, 1, 2, 1, 0, 0, 0);
    step(0, 1, 3, 1, 1, 1, 2, 1, 0, 0, 0);
    idle(2);

    // randomized traffic with small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom),
           5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), ADDR_W'($urandom),
           ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
